// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   WIDTH_DEF / CNT_W_DEF : default data width and shift-count width
//   OP_ROL/OP_SLL/OP_ROR/OP_SRL : 2-bit operation encodings on in_op
package shifter_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned CNT_W_DEF = 4;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One combinational barrel-shifter stage: shifts/rotates by the fixed amount
// AMT when en is set, otherwise passes data through unchanged.
// Ports:
//   data  in  WIDTH  operand
//   en    in  1      apply this stage's shift
//   op    in  2      OP_ROL / OP_SLL / OP_ROR / OP_SRL
//   arith in  1      op SRL fills with data MSB instead of zero
//   res   out WIDTH  result
module shift_stage
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned AMT   = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic             arith,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = data;
    if (en) begin
      case (op)
        OP_ROL:  res = {data[WIDTH-1-AMT:0], data[WIDTH-1:WIDTH-AMT]};
        OP_SLL:  res = data << AMT;
        OP_ROR:  res = {data[AMT-1:0], data[WIDTH-1:AMT]};
        OP_SRL:  res = arith ? WIDTH'($signed(data) >>> AMT) : (data >> AMT);
        default: res = data;
      endcase
    end
  end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Two-stage elastic barrel shifter/rotator. Stage A applies the low half of
// the count bits, stage B the high half; each stage is a valid/data register
// with valid/ready handshaking, sustaining one op per cycle.
// Optional build macro: SHIFT_ARITH_EN adds in_arith (op SRL becomes SRA
// when in_arith=1).
// Ports:
//   clk, rst_n (async, active low), flush (sync kill of in-flight ops)
//   in_valid/in_ready/in_data/in_cnt/in_op [/in_arith] : operand side
//   out_valid/out_ready/out_data                       : result side
module barrel_shift_pipe
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
`ifdef SHIFT_ARITH_EN
  input  logic             in_arith,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned LO_W = CNT_W / 2;
  localparam int unsigned HI_W = CNT_W - LO_W;

  logic             arith_in;
  logic             a_valid, b_valid;
  logic [WIDTH-1:0] a_data, b_data;
  logic [1:0]       a_op;
  logic [HI_W-1:0]  a_cnt_hi;
  logic             a_arith;
  logic             b_load, a_adv, a_load;

  logic [WIDTH-1:0] a_chain [LO_W+1];
  logic [WIDTH-1:0] b_chain [HI_W+1];

`ifdef SHIFT_ARITH_EN
  assign arith_in = in_arith;
`else
  assign arith_in = 1'b0;
`endif

  // Handshake: stage B refills when empty or draining; stage A refills when
  // empty or moving into B, so in_ready only drops with both stages full.
  assign b_load   = !b_valid || out_ready;
  assign a_adv    = a_valid && b_load;
  assign a_load   = !a_valid || b_load;
  assign in_ready = a_load && !flush;

  assign out_valid = b_valid;
  assign out_data  = b_data;

  assign a_chain[0] = in_data;
  for (genvar i = 0; i < LO_W; i++) begin : g_stage_a
    shift_stage #(.WIDTH(WIDTH), .AMT(1 << i)) u_shift (
      .data  (a_chain[i]),
      .en    (in_cnt[i]),
      .op    (in_op),
      .arith (arith_in),
      .res   (a_chain[i+1])
    );
  end

  assign b_chain[0] = a_data;
  for (genvar j = 0; j < HI_W; j++) begin : g_stage_b
    shift_stage #(.WIDTH(WIDTH), .AMT(1 << (LO_W + j))) u_shift (
      .data  (b_chain[j]),
      .en    (a_cnt_hi[j]),
      .op    (a_op),
      .arith (a_arith),
      .res   (b_chain[j+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid  <= 1'b0;
      a_data   <= '0;
      a_op     <= OP_ROL;
      a_cnt_hi <= '0;
      a_arith  <= 1'b0;
    end else if (flush) begin
      a_valid <= 1'b0;
    end else if (a_load) begin
      a_valid <= in_valid;
      if (in_valid) begin
        a_data   <= a_chain[LO_W];
        a_op     <= in_op;
        a_cnt_hi <= in_cnt[CNT_W-1:LO_W];
        a_arith  <= arith_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid <= 1'b0;
      b_data  <= '0;
    end else if (flush) begin
      b_valid <= 1'b0;
    end else if (b_load) begin
      b_valid <= a_valid;
      if (a_adv) b_data <= b_chain[HI_W];
    end
  end

endmodule
